c1541_gcr_track: RTL and testbench

C1541_GCR_TRACK -- requirements
Module: c1541_gcr_track

---
 rtl/c1541_pkg.sv | 20 ++
 rtl/c1541_bitclk.sv | 38 +++
 rtl/c1541_gcr_track.sv | 168 ++++++++++++++++
 tb/tb_c1541_gcr_track.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/c1541_pkg.sv
// rtl/c1541_pkg.sv - shared encodings and bit-cell timing constants for the GCR track model
package c1541_pkg;

    localparam int ADDR_W    = 13;
    localparam int CELL_MUL  = 8;
    localparam int CELL_BASE = 16;
    localparam int CELL_W    = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    // Reload value for the bit-cell down-counter: one cell lasts 8*(16-freq) clk32 cycles.
    function automatic logic [CELL_W-1:0] cell_reload(input logic [1:0] freq);
        cell_reload = CELL_W'(CELL_MUL * (CELL_BASE - int'(freq)) - 1);
    endfunction

endpackage

// File: rtl/c1541_bitclk.sv
// rtl/c1541_bitclk.sv - bit-cell timer producing one tick per GCR bit cell
module c1541_bitclk
    import c1541_pkg::*;
(
    input  logic       clk32,
    input  logic       reset,
    input  logic [1:0] freq,
    input  logic       run,
    output logic       tick
);

    logic [CELL_W-1:0] cnt_q;
    logic [CELL_W-1:0] cnt_d;

    // Counter parked at zero while stopped so the first cell ticks immediately on start;
    // freq is only sampled at reload, so a zone change never truncates the running cell.
    always_comb begin
        tick  = run && (cnt_q == '0);
        cnt_d = cnt_q;
        if (!run) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cell_reload(freq);
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Cell counter register.
    always_ff @(posedge clk32) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/c1541_gcr_track.sv
// rtl/c1541_gcr_track.sv - 1541 track head model: GCR byte stream read/write against a track buffer
module c1541_gcr_track
    import c1541_pkg::*;
#(
    parameter int BYTE_N_LEN = 32,
    parameter int SYNC_BITS  = 10
) (
    input  logic              clk32,
    input  logic              reset,
    input  logic              mtr,
    input  logic [1:0]        freq,
    input  logic              mode,
    input  logic [7:0]        dout,
    input  logic              wps_n,
    input  logic [ADDR_W-1:0] track_len,
    output logic [ADDR_W-1:0] buf_addr,
    input  logic [7:0]        buf_din,
    output logic [7:0]        buf_dout,
    output logic              buf_we,
    output logic [7:0]        din,
    output logic              sync_n,
    output logic              byte_n
);

    localparam int RUN_W = $clog2(SYNC_BITS + 1);
    localparam int BN_W  = $clog2(BYTE_N_LEN + 1);
    localparam logic [RUN_W-1:0] SYNC_MAX = RUN_W'(SYNC_BITS);
    localparam logic [BN_W-1:0]  BN_LOAD  = BN_W'(BYTE_N_LEN);

    state_e            state_q;
    state_e            state_d;
    logic              tick;
    logic              idle_req;
    logic [2:0]        bit_cnt_q;
    logic [7:0]        shreg_q;
    logic [6:0]        asm_q;
    logic [2:0]        asm_cnt_q;
    logic [RUN_W-1:0]  run_cnt_q;
    logic [RUN_W-1:0]  run_nx;
    logic [BN_W-1:0]   bn_cnt_q;
    logic              adv_q;
    logic              wp_seen_q;
    logic [ADDR_W-1:0] buf_addr_q;
    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W-1:0] addr_nx;
    logic [7:0]        din_q;
    logic [7:0]        buf_dout_q;
    logic              buf_we_q;
    logic              rd_bit;
    logic              in_sync;
    logic              byte_last;

    c1541_bitclk u_bitclk (
        .clk32 (clk32),
        .reset (reset),
        .freq  (freq),
        .run   (state_q != ST_IDLE),
        .tick  (tick)
    );

    assign idle_req  = !mtr || (track_len == '0);
    assign byte_last = (bit_cnt_q == 3'd7);
    // The first bit of a byte comes straight from the buffer; the rest from the shifter.
    assign rd_bit    = (bit_cnt_q == 3'd0) ? buf_din[7] : shreg_q[7];
    assign run_nx    = !rd_bit ? '0 : ((run_cnt_q == SYNC_MAX) ? run_cnt_q : run_cnt_q + 1'b1);
    assign in_sync   = (run_nx == SYNC_MAX);
    assign addr_inc  = buf_addr_q + 1'b1;
    // >= also catches a track that shrank underneath the current address.
    assign addr_nx   = (addr_inc >= track_len) ? '0 : addr_inc;

    // Next state: idle is immediate, read/write swaps wait for a quiet byte boundary.
    always_comb begin
        state_d = state_q;
        if (idle_req) begin
            state_d = ST_IDLE;
        end else if (state_q == ST_IDLE || (bit_cnt_q == 3'd0 && !tick)) begin
            state_d = (!mode && wps_n) ? ST_WRITE : ST_READ;
        end
    end

    // State register.
    always_ff @(posedge clk32) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Bit/byte datapath: shifting, sync detection, byte events, buffer writes, address stepping.
    always_ff @(posedge clk32) begin
        if (reset) begin
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            asm_q      <= '0;
            asm_cnt_q  <= '0;
            run_cnt_q  <= '0;
            bn_cnt_q   <= '0;
            adv_q      <= 1'b0;
            wp_seen_q  <= 1'b0;
            buf_addr_q <= '0;
            din_q      <= '0;
            buf_dout_q <= '0;
            buf_we_q   <= 1'b0;
        end else if (idle_req || state_q == ST_IDLE) begin
            bit_cnt_q <= '0;
            asm_q     <= '0;
            asm_cnt_q <= '0;
            run_cnt_q <= '0;
            bn_cnt_q  <= '0;
            adv_q     <= 1'b0;
            wp_seen_q <= 1'b0;
            buf_we_q  <= 1'b0;
        end else begin
            buf_we_q <= 1'b0;
            adv_q    <= 1'b0;
            if (bn_cnt_q != '0) begin
                bn_cnt_q <= bn_cnt_q - 1'b1;
            end
            // Address steps one cycle after the byte so a write strobe still sees its own address.
            if (adv_q) begin
                buf_addr_q <= addr_nx;
            end
            if (state_q == ST_WRITE && !wps_n) begin
                wp_seen_q <= 1'b1;
            end
            if (tick) begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
                if (byte_last) begin
                    adv_q <= 1'b1;
                end
                if (state_q == ST_READ) begin
                    shreg_q   <= (bit_cnt_q == 3'd0) ? {buf_din[6:0], 1'b0} : {shreg_q[6:0], 1'b0};
                    asm_q     <= {asm_q[5:0], rd_bit};
                    run_cnt_q <= run_nx;
                    if (in_sync) begin
                        asm_cnt_q <= '0;
                    end else begin
                        asm_cnt_q <= asm_cnt_q + 1'b1;
                        if (asm_cnt_q == 3'd7) begin
                            din_q    <= {asm_q, rd_bit};
                            bn_cnt_q <= BN_LOAD;
                        end
                    end
                end else begin
                    run_cnt_q <= '0;
                    asm_cnt_q <= '0;
                    if (byte_last) begin
                        bn_cnt_q  <= BN_LOAD;
                        wp_seen_q <= 1'b0;
                        if (wps_n && !wp_seen_q) begin
                            buf_we_q   <= 1'b1;
                            buf_dout_q <= dout;
                        end
                    end
                end
            end
        end
    end

    assign buf_addr = buf_addr_q;
    assign buf_dout = buf_dout_q;
    assign buf_we   = buf_we_q;
    assign din      = din_q;
    assign byte_n   = (bn_cnt_q == '0);
    assign sync_n   = !(state_q == ST_READ && run_cnt_q == SYNC_MAX);

endmodule

// File: tb/tb_c1541_gcr_track.sv
// tb/tb_c1541_gcr_track.sv - scoreboard bench for c1541_gcr_track
module tb_c1541_gcr_track;

    logic        clk32 = 1'b0;
    logic        reset = 1'b1;
    logic        mtr = 1'b0;
    logic [1:0]  freq = 2'd3;
    logic        mode = 1'b1;
    logic [7:0]  dout = 8'h00;
    logic        wps_n = 1'b1;
    logic [12:0] track_len = 13'd0;
    logic [12:0] buf_addr;
    logic [7:0]  buf_din = 8'h00;
    logic [7:0]  buf_dout;
    logic        buf_we;
    logic [7:0]  din;
    logic        sync_n;
    logic        byte_n;

    c1541_gcr_track dut (
        .clk32     (clk32),
        .reset     (reset),
        .mtr       (mtr),
        .freq      (freq),
        .mode      (mode),
        .dout      (dout),
        .wps_n     (wps_n),
        .track_len (track_len),
        .buf_addr  (buf_addr),
        .buf_din   (buf_din),
        .buf_dout  (buf_dout),
        .buf_we    (buf_we),
        .din       (din),
        .sync_n    (sync_n),
        .byte_n    (byte_n)
    );

    always #5 clk32 = ~clk32;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0] mem [0:15];

    always @(posedge clk32) cyc <= cyc + 1;
    always @(posedge clk32) buf_din <= mem[buf_addr[3:0]];

    logic [7:0]  exp_din_q [$];
    logic [12:0] exp_addr_q [$];
    logic [12:0] exp_we_q [$];
    logic [7:0]  exp_dout = 8'h00;
    int          exp_ival = 0;
    bit          din_chk_en = 1'b0;
    bit          sync_chk_en = 1'b0;
    bit          addr_chk_en = 1'b0;
    bit          we_chk_en = 1'b0;

    logic        byte_n_prev = 1'b1;
    logic        sync_prev = 1'b1;
    logic        we_prev = 1'b0;
    logic [12:0] addr_prev = 13'd0;
    int          bn_low = 0;
    int          last_bn_fall = 0;
    int          sync_fall = 0;
    int          sync_fall_cnt = 0;
    int          last_addr_chg = 0;
    int          we_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk32) begin
        if (byte_n_prev && !byte_n) begin
            last_bn_fall = cyc;
            bn_low = 0;
            if (din_chk_en) begin
                check("no_byte_n_in_sync", sync_n, 1);
                check("byte_event_expected", exp_din_q.size() != 0, 1);
                if (exp_din_q.size() != 0) check("din", din, exp_din_q.pop_front());
            end
        end
        if (!byte_n) bn_low++;
        if (!byte_n_prev && byte_n && din_chk_en) check("byte_n_len", bn_low, 32);

        if (sync_chk_en && sync_prev && !sync_n) begin
            sync_fall = cyc;
            sync_fall_cnt++;
            check("sync_after_byte", cyc - last_bn_fall, 208);
        end
        if (sync_chk_en && !sync_prev && sync_n) check("sync_len", cyc - sync_fall, 728);

        if (addr_chk_en && buf_addr != addr_prev) begin
            check("addr_change_expected", exp_addr_q.size() != 0, 1);
            if (exp_addr_q.size() != 0) check("addr_seq", buf_addr, exp_addr_q.pop_front());
            if (exp_ival != 0) check("addr_interval", cyc - last_addr_chg, exp_ival);
            last_addr_chg = cyc;
        end

        if (buf_we) begin
            if (!we_prev) we_cnt++;
            if (we_chk_en) begin
                check("we_single_cycle", we_prev, 0);
                check("we_sync_n", sync_n, 1);
                check("we_expected", exp_we_q.size() != 0, 1);
                if (exp_we_q.size() != 0) begin
                    check("we_addr", buf_addr, exp_we_q.pop_front());
                    check("we_dout", buf_dout, exp_dout);
                end
            end
        end

        byte_n_prev = byte_n;
        sync_prev = sync_n;
        we_prev = buf_we;
        addr_prev = buf_addr;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk32);
    endtask

    task automatic wait_din(input int budget);
        int t = 0;
        while (exp_din_q.size() != 0 && t < budget) begin @(negedge clk32); t++; end
        check("din_queue_drained", exp_din_q.size(), 0);
    endtask

    task automatic wait_addr(input int budget);
        int t = 0;
        while (exp_addr_q.size() != 0 && t < budget) begin @(negedge clk32); t++; end
        check("addr_queue_drained", exp_addr_q.size(), 0);
    endtask

    task automatic wait_we(input int budget);
        int t = 0;
        while (exp_we_q.size() != 0 && t < budget) begin @(negedge clk32); t++; end
        check("we_queue_drained", exp_we_q.size(), 0);
    endtask

    task automatic wait_byte_n_fall(input int budget);
        int t = 0;
        @(negedge clk32);
        while (byte_n !== 1'b0 && t < budget) begin @(negedge clk32); t++; end
        check("byte_n_fall_seen", byte_n, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycles(3);
        reset = 1'b0;
        cycles(1);
    endtask

    task automatic check_reset_outputs(input string phase);
        check({phase, "_buf_addr"}, buf_addr, 0);
        check({phase, "_din"}, din, 0);
        check({phase, "_buf_dout"}, buf_dout, 0);
        check({phase, "_buf_we"}, buf_we, 0);
        check({phase, "_byte_n"}, byte_n, 1);
        check({phase, "_sync_n"}, sync_n, 1);
    endtask

    initial begin
        int n0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;

        // reset state
        cycles(4);
        check_reset_outputs("reset");
        reset = 1'b0;
        cycles(2);

        // sync detection and byte assembly on FF FF 52
        mem[0] = 8'hFF; mem[1] = 8'hFF; mem[2] = 8'h52;
        track_len = 13'd3; mode = 1'b1; freq = 2'd3;
        exp_din_q.push_back(8'hFF); exp_din_q.push_back(8'h52);
        exp_din_q.push_back(8'hFF); exp_din_q.push_back(8'h52);
        din_chk_en = 1'b1; sync_chk_en = 1'b1;
        mtr = 1'b1;
        wait_din(8000);
        cycles(40);
        check("sync_events", sync_fall_cnt, 2);
        din_chk_en = 1'b0; sync_chk_en = 1'b0;
        mtr = 1'b0;
        cycles(2);
        do_reset();

        // address sequence, wrap, bit-cell period for two zones, track shrink
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        track_len = 13'd5; freq = 2'd3; mode = 1'b1;
        exp_ival = 0; addr_chk_en = 1'b1;
        exp_addr_q.push_back(13'd1);
        mtr = 1'b1;
        wait_addr(2000);
        exp_ival = 832;
        exp_addr_q.push_back(13'd2); exp_addr_q.push_back(13'd3); exp_addr_q.push_back(13'd4);
        exp_addr_q.push_back(13'd0); exp_addr_q.push_back(13'd1);
        wait_addr(5000);
        freq = 2'd0; exp_ival = 0;
        exp_addr_q.push_back(13'd2);
        wait_addr(2000);
        exp_ival = 1024;
        exp_addr_q.push_back(13'd3); exp_addr_q.push_back(13'd4);
        wait_addr(3000);
        track_len = 13'd3;
        exp_addr_q.push_back(13'd0);
        wait_addr(2000);
        addr_chk_en = 1'b0;
        mtr = 1'b0; freq = 2'd3;
        cycles(2);
        do_reset();

        // write mode, dout change, write protect arriving mid-byte
        track_len = 13'd4; mode = 1'b0; wps_n = 1'b1; dout = 8'h55; exp_dout = 8'h55;
        we_chk_en = 1'b1;
        exp_we_q.push_back(13'd0); exp_we_q.push_back(13'd1); exp_we_q.push_back(13'd2);
        exp_we_q.push_back(13'd3); exp_we_q.push_back(13'd0);
        mtr = 1'b1;
        wait_we(6000);
        dout = 8'hA3; exp_dout = 8'hA3;
        exp_we_q.push_back(13'd1);
        wait_we(1200);
        cycles(300);
        wps_n = 1'b0;
        n0 = we_cnt;
        cycles(2000);
        check("wp_no_we", we_cnt, n0);
        check("wp_addr_advances", buf_addr, 0);
        we_chk_en = 1'b0;
        mtr = 1'b0; wps_n = 1'b1;
        cycles(2);
        do_reset();

        // motor drop mid-byte freezes the head
        mem[0] = 8'hFF; mem[1] = 8'hFF; mem[2] = 8'h52;
        track_len = 13'd3; mode = 1'b1;
        mtr = 1'b1;
        wait_byte_n_fall(2000);
        check("idle_first_din", din, 8'hFF);
        cycles(5);
        check("idle_byte_n_low_before", byte_n, 0);
        mtr = 1'b0;
        cycles(2);
        check("idle_byte_n", byte_n, 1);
        check("idle_sync_n", sync_n, 1);
        check("idle_addr", buf_addr, 1);
        check("idle_we", buf_we, 0);
        cycles(1500);
        check("idle_addr_frozen", buf_addr, 1);
        check("idle_din_kept", din, 8'hFF);
        check("idle_byte_n_held", byte_n, 1);

        // reset in the middle of a write byte
        track_len = 13'd4; mode = 1'b0; wps_n = 1'b1; dout = 8'h77; exp_dout = 8'h77;
        we_chk_en = 1'b1;
        exp_we_q.push_back(13'd1);
        mtr = 1'b1;
        wait_we(2000);
        cycles(400);
        n0 = we_cnt;
        reset = 1'b1;
        cycles(2);
        check_reset_outputs("midreset");
        mtr = 1'b0;
        reset = 1'b0;
        cycles(1000);
        check("midreset_no_we", we_cnt, n0);
        we_chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
